// File: rtl/gpio_arb_pkg.sv
// Shared types and default widths for the two-master GPIO register-port arbiter.
// The optional lock/hold feature is enabled by defining GPIO_ARB_LOCK_EN.
package gpio_arb_pkg;

  localparam int GPIO_AW = 2;
  localparam int GPIO_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  function automatic master_id_e other_master(input master_id_e id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/gpio_arb_rr.sv
// Round-robin winner select for two requesters, plus the priority pointer register.
module gpio_arb_rr
  import gpio_arb_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  input  logic served,
  output logic winner
);

  master_id_e ptr_q, ptr_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    winner = ptr_q;
    if (req0 && !req1) begin
      winner = M0;
    end else if (req1 && !req0) begin
      winner = M1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = other_master(master_id_e'(served));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= M0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Two-master arbiter/sequencer in front of the gpio_top register port (IDLE -> ACCESS -> RESP).
// Define GPIO_ARB_LOCK_EN to add m0_lock/m1_lock and back-to-back locked accesses up to MAX_HOLD.
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int AW = GPIO_AW,
  parameter int DW = GPIO_DW
`ifdef GPIO_ARB_LOCK_EN
  ,
  parameter int MAX_HOLD = 4
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_a,
  input  logic [DW-1:0] m0_wd,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_a,
  input  logic [DW-1:0] m1_wd,
`ifdef GPIO_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rd,
  output logic [DW-1:0] m1_rd,
  output logic [AW-1:0] gpio_a,
  output logic          gpio_we,
  output logic [DW-1:0] gpio_wd,
  input  logic [DW-1:0] gpio_rd,
  output logic          busy
);

  arb_state_e    state_q, state_d;
  master_id_e    id_q, id_d;
  logic [AW-1:0] a_q, a_d;
  logic          we_q, we_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] m0_rd_q, m0_rd_d;
  logic [DW-1:0] m1_rd_q, m1_rd_d;

  logic          rr_winner;
  logic          rr_advance;
  logic          load_cmd;
  master_id_e    load_id;
  logic          in_access;
  logic          in_resp;

`ifdef GPIO_ARB_LOCK_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;
  logic          keep_bus;

  assign keep_bus = (id_q == M1) ? (m1_lock & m1_req) : (m0_lock & m0_req);
`endif

  gpio_arb_rr u_rr (
    .CLK     (CLK),
    .RST     (RST),
    .req0    (m0_req),
    .req1    (m1_req),
    .advance (rr_advance),
    .served  (id_q),
    .winner  (rr_winner)
  );

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  always_comb begin
    state_d    = state_q;
    rr_advance = 1'b0;
    load_cmd   = 1'b0;
    load_id    = master_id_e'(rr_winner);
`ifdef GPIO_ARB_LOCK_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
        hold_d = '0;
`endif
        if (m0_req || m1_req) begin
          load_cmd = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
`ifdef GPIO_ARB_LOCK_EN
        hold_d = hold_q + HW'(1);
`endif
        state_d = RESP;
      end
      RESP: begin
        state_d    = IDLE;
        rr_advance = 1'b1;
`ifdef GPIO_ARB_LOCK_EN
        // hold_q counts accesses already done in this tenure, so MAX_HOLD caps the burst.
        if (keep_bus && (hold_q < HOLD_LIMIT)) begin
          load_cmd   = 1'b1;
          load_id    = id_q;
          rr_advance = 1'b0;
          state_d    = ACCESS;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    id_d    = id_q;
    a_d     = a_q;
    we_d    = we_q;
    wd_d    = wd_q;
    m0_rd_d = m0_rd_q;
    m1_rd_d = m1_rd_q;
    if (load_cmd) begin
      id_d = load_id;
      if (load_id == M1) begin
        a_d  = m1_a;
        we_d = m1_we;
        wd_d = m1_wd;
      end else begin
        a_d  = m0_a;
        we_d = m0_we;
        wd_d = m0_wd;
      end
    end
    if (in_access && !we_q) begin
      if (id_q == M1) begin
        m1_rd_d = gpio_rd;
      end else begin
        m0_rd_d = gpio_rd;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      id_q    <= M0;
      a_q     <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      m0_rd_q <= '0;
      m1_rd_q <= '0;
`ifdef GPIO_ARB_LOCK_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      a_q     <= a_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      m0_rd_q <= m0_rd_d;
      m1_rd_q <= m1_rd_d;
`ifdef GPIO_ARB_LOCK_EN
      hold_q  <= hold_d;
`endif
    end
  end

  // A reset landing mid-access aborts it, so the handshake pulses are suppressed too.
  assign m0_gnt    = in_access && (id_q == M0) && !RST;
  assign m1_gnt    = in_access && (id_q == M1) && !RST;
  assign m0_rvalid = in_resp && (id_q == M0) && !RST;
  assign m1_rvalid = in_resp && (id_q == M1) && !RST;
  assign m0_rd     = m0_rd_q;
  assign m1_rd     = m1_rd_q;
  assign gpio_a    = a_q;
  assign gpio_wd   = wd_q;
  assign gpio_we   = in_access & we_q & ~RST;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: directed vector table, fairness/lock sequences and a random run
// against a transaction-schedule model. Lock sequence is built only with GPIO_ARB_LOCK_EN.
module tb_gpio_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_a, m1_a;
  logic [31:0] m0_wd, m1_wd;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rd, m1_rd;
  logic [1:0]  gpio_a;
  logic        gpio_we;
  logic [31:0] gpio_wd, gpio_rd;
  logic        busy;
`ifdef GPIO_ARB_LOCK_EN
  logic        m0_lock = 1'b0;
  logic        m1_lock = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  gpio_arbiter dut (
    .CLK       (CLK),
    .RST       (RST),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_a      (m0_a),
    .m0_wd     (m0_wd),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_a      (m1_a),
    .m1_wd     (m1_wd),
`ifdef GPIO_ARB_LOCK_EN
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
`endif
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_rd     (m0_rd),
    .m1_rd     (m1_rd),
    .gpio_a    (gpio_a),
    .gpio_we   (gpio_we),
    .gpio_wd   (gpio_wd),
    .gpio_rd   (gpio_rd),
    .busy      (busy)
  );

  // Stand-in for gpio_top's register file: combinational read, write on the clock edge.
  logic        env_reload = 1'b0;
  logic [31:0] env_regs [4];

  always @(posedge CLK) begin
    if (env_reload) begin
      env_regs[0] <= 32'd5;
      env_regs[1] <= 32'd7;
      env_regs[2] <= 32'h11;
      env_regs[3] <= 32'h22;
    end else if (gpio_we) begin
      env_regs[gpio_a] <= gpio_wd;
    end
  end

  assign gpio_rd = env_regs[gpio_a];

  typedef struct {
    int rst;
    int r0, we0, a0, wd0;
    int r1, we1, a1, wd1;
    int g0, g1, v0, v1, gwe, ga, gwd, bsy, rd0, rd1;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int rst, input int r0, input int we0, input int a0,
                                input int wd0, input int r1, input int we1, input int a1,
                                input int wd1);
    RST    = rst[0];
    m0_req = r0[0];
    m0_we  = we0[0];
    m0_a   = a0[1:0];
    m0_wd  = wd0;
    m1_req = r1[0];
    m1_we  = we1[0];
    m1_a   = a1[1:0];
    m1_wd  = wd1;
  endtask

  task automatic do_reset();
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    env_reload = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    env_reload = 1'b0;
    RST = 1'b0;
  endtask

  task automatic check_all(input string tag, input int g0, input int g1, input int v0,
                           input int v1, input int gwe, input int ga, input int gwd,
                           input int bsy, input logic [31:0] rd0, input logic [31:0] rd1);
    check_output({tag, " m0_gnt"},    32'(m0_gnt),    g0);
    check_output({tag, " m1_gnt"},    32'(m1_gnt),    g1);
    check_output({tag, " m0_rvalid"}, 32'(m0_rvalid), v0);
    check_output({tag, " m1_rvalid"}, 32'(m1_rvalid), v1);
    check_output({tag, " gpio_we"},   32'(gpio_we),   gwe);
    check_output({tag, " gpio_a"},    32'(gpio_a),    ga);
    check_output({tag, " gpio_wd"},   gpio_wd,        gwd);
    check_output({tag, " busy"},      32'(busy),      bsy);
    check_output({tag, " m0_rd"},     m0_rd,          rd0);
    check_output({tag, " m1_rd"},     m1_rd,          rd1);
  endtask

  // Random-run reference: each accepted request occupies a 3-cycle slot starting in its IDLE cycle.
  int          acc_start, next_free, mptr, cur_id, cur_we, cur_a, cur_wd, last_a, last_wd;
  int          rst_c, req_now0, req_now1, in_acc, in_rsp;
  int          pend[2], pwe[2], pa[2], pwd[2];
  logic [31:0] rd_exp[2];
  logic [31:0] mregs[4];

  int gids[$];
  int gcyc[$];
  int idle_cnt, cyc;
`ifdef GPIO_ARB_LOCK_EN
  int exp_ids[6]  = '{0, 1, 1, 1, 1, 0};
  int exp_gaps[5] = '{3, 2, 2, 2, 3};
`endif

  initial begin
    do_reset();

    // rst, m0 {req,we,a,wd}, m1 {req,we,a,wd} | g0 g1 v0 v1 we a wd busy rd0 rd1
    vecs.push_back('{1, 1,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0, 1,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0, 1,0,0,0, 0,0,0,0, 1,0,0,0,0,0,0,1,0,0});
    vecs.push_back('{0, 0,0,0,0, 0,0,0,0, 0,0,1,0,0,0,0,1,5,0});
    vecs.push_back('{0, 1,1,2,3, 0,0,0,0, 0,0,0,0,0,0,0,0,5,0});
    vecs.push_back('{0, 1,1,2,3, 0,0,0,0, 1,0,0,0,1,2,3,1,5,0});
    vecs.push_back('{0, 0,0,0,0, 0,0,0,0, 0,0,1,0,0,2,3,1,5,0});
    vecs.push_back('{1, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,2,3,0,5,0});
    vecs.push_back('{0, 1,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0, 1,0,0,0, 1,0,1,0, 1,0,0,0,0,0,0,1,0,0});
    vecs.push_back('{0, 0,0,0,0, 1,0,1,0, 0,0,1,0,0,0,0,1,5,0});
    vecs.push_back('{0, 0,0,0,0, 1,0,1,0, 0,0,0,0,0,0,0,0,5,0});
    vecs.push_back('{0, 0,0,0,0, 1,0,1,0, 0,1,0,0,0,1,0,1,5,0});
    vecs.push_back('{0, 0,0,0,0, 0,0,0,0, 0,0,0,1,0,1,0,1,5,7});
    vecs.push_back('{0, 0,0,0,0, 1,1,3,9, 0,0,0,0,0,1,0,0,5,7});
    vecs.push_back('{1, 0,0,0,0, 1,1,3,9, 0,0,0,0,0,3,9,1,5,7});
    vecs.push_back('{0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0, 1,0,1,0, 1,0,2,0, 0,0,0,0,0,0,0,0,0,0});
    vecs.push_back('{0, 1,0,1,0, 1,0,2,0, 1,0,0,0,0,1,0,1,0,0});
    vecs.push_back('{0, 0,0,0,0, 1,0,2,0, 0,0,1,0,0,1,0,1,7,0});
    vecs.push_back('{0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,1,0,0,7,0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].r0, vecs[i].we0, vecs[i].a0, vecs[i].wd0,
                     vecs[i].r1, vecs[i].we1, vecs[i].a1, vecs[i].wd1);
      @(negedge CLK);
      check_all($sformatf("row%0d", i), vecs[i].g0, vecs[i].g1, vecs[i].v0, vecs[i].v1,
                vecs[i].gwe, vecs[i].ga, vecs[i].gwd, vecs[i].bsy, vecs[i].rd0, vecs[i].rd1);
      @(posedge CLK);
      #1;
    end
    check_output("aborted write left A=3 intact", env_regs[3], 32'h22);

    // Fairness: both masters keep requesting; grants must alternate with an idle cycle each.
    do_reset();
    apply_stimulus(0, 1, 0, 0, 0, 1, 0, 1, 0);
    idle_cnt = 0;
    cyc = 0;
    while (gids.size() < 6 && cyc < 40) begin
      @(negedge CLK);
      if (!busy) idle_cnt++;
      if (m0_gnt) gids.push_back(0);
      if (m1_gnt) gids.push_back(1);
      @(posedge CLK);
      #1;
      cyc++;
    end
    check_output("fair grant count", 32'(gids.size()), 6);
    foreach (gids[k]) check_output($sformatf("fair grant %0d id", k), gids[k], k % 2);
    check_output("fair idle cycles", idle_cnt, 6);

    // Random run against the slot-schedule model.
    do_reset();
    acc_start = -10;
    next_free = 0;
    mptr      = 0;
    cur_id    = 0;
    cur_we    = 0;
    cur_a     = 0;
    cur_wd    = 0;
    last_a    = 0;
    last_wd   = 0;
    rd_exp[0] = '0;
    rd_exp[1] = '0;
    mregs[0]  = 32'd5;
    mregs[1]  = 32'd7;
    mregs[2]  = 32'h11;
    mregs[3]  = 32'h22;
    for (int i = 0; i < 2; i++) pend[i] = 0;
    for (int c = 0; c < 600; c++) begin
      rst_c = ($urandom_range(99) == 0) ? 1 : 0;
      for (int i = 0; i < 2; i++) begin
        if (pend[i] == 0 && $urandom_range(2) == 0) begin
          pend[i] = 1;
          pwe[i]  = int'($urandom_range(1));
          pa[i]   = int'($urandom_range(3));
          pwd[i]  = int'($urandom);
        end
      end
      req_now0 = pend[0];
      req_now1 = pend[1];
      apply_stimulus(rst_c, pend[0], pwe[0], pa[0], pwd[0], pend[1], pwe[1], pa[1], pwd[1]);
      in_acc = (c == acc_start + 1) ? 1 : 0;
      in_rsp = (c == acc_start + 2) ? 1 : 0;
      @(negedge CLK);
      check_all($sformatf("rnd%0d", c),
                (in_acc == 1 && cur_id == 0 && rst_c == 0) ? 1 : 0,
                (in_acc == 1 && cur_id == 1 && rst_c == 0) ? 1 : 0,
                (in_rsp == 1 && cur_id == 0 && rst_c == 0) ? 1 : 0,
                (in_rsp == 1 && cur_id == 1 && rst_c == 0) ? 1 : 0,
                (in_acc == 1 && cur_we == 1 && rst_c == 0) ? 1 : 0,
                last_a, last_wd, (in_acc == 1 || in_rsp == 1) ? 1 : 0,
                rd_exp[0], rd_exp[1]);
      if (rst_c == 1) begin
        acc_start = -10;
        next_free = c + 1;
        mptr      = 0;
        last_a    = 0;
        last_wd   = 0;
        rd_exp[0] = '0;
        rd_exp[1] = '0;
      end else begin
        if (in_acc == 1) begin
          if (cur_we == 1) mregs[cur_a] = cur_wd;
          else rd_exp[cur_id] = mregs[cur_a];
          pend[cur_id] = 0;
        end
        if (in_rsp == 1) mptr = 1 - cur_id;
        if (c >= next_free && (req_now0 == 1 || req_now1 == 1)) begin
          cur_id    = (req_now0 == 1 && req_now1 == 1) ? mptr : ((req_now1 == 1) ? 1 : 0);
          cur_we    = pwe[cur_id];
          cur_a     = pa[cur_id];
          cur_wd    = pwd[cur_id];
          last_a    = cur_a;
          last_wd   = cur_wd;
          acc_start = c;
          next_free = c + 3;
        end
      end
      @(posedge CLK);
      #1;
    end

`ifdef GPIO_ARB_LOCK_EN
    // Lock: m1 keeps the bus for MAX_HOLD back-to-back accesses, then m0 gets its turn.
    do_reset();
    m1_lock = 1'b1;
    apply_stimulus(0, 1, 0, 0, 0, 1, 0, 1, 0);
    gids.delete();
    cyc = 0;
    while (gids.size() < 6 && cyc < 60) begin
      @(negedge CLK);
      if (m0_gnt) begin gids.push_back(0); gcyc.push_back(cyc); end
      if (m1_gnt) begin gids.push_back(1); gcyc.push_back(cyc); end
      @(posedge CLK);
      #1;
      cyc++;
    end
    m1_lock = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_output("lock grant count", 32'(gids.size()), 6);
    foreach (gids[k]) begin
      if (k < 6) check_output($sformatf("lock grant %0d id", k), gids[k], exp_ids[k]);
      if (k > 0 && k < 6)
        check_output($sformatf("lock gap %0d", k), gcyc[k] - gcyc[k-1], exp_gaps[k-1]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
Name: gpio_arbiter

Overview:
- Two-master arbiter and access sequencer in front of the single register port of gpio_top (A, WE, WD, RD).
- Lets the MIPS core's memory-mapped IO path (master 0) and a secondary host/debug requester (master 1) share the GPIO block.
- Serializes their accesses with round-robin fairness and returns completion and read data through a req/gnt/rvalid handshake.
- Sits between the requesters and gpio_top; gpio_top's gpi/gpo pins are untouched.

Parameters:
- AW, 2, GPIO register address width.
- DW, 32, data width.
- MAX_HOLD, 4, maximum consecutive locked accesses per master (used only with GPIO_ARB_LOCK_EN).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held with command until gnt seen.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_a / m1_a  in  AW  register address.
- m0_wd / m1_wd  in  DW  write data.
- m0_gnt / m1_gnt  out  1  one-cycle pulse: command accepted.
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse: access complete, rd valid.
- m0_rd / m1_rd  out  DW  read data; holds the last captured value.
- gpio_a  out  AW  to gpio_top A.
- gpio_we  out  1  to gpio_top WE.
- gpio_wd  out  DW  to gpio_top WD.
- gpio_rd  in  DW  from gpio_top RD (combinational read).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- On reset:
  - state = IDLE; priority pointer = m0.
  - All gnt/rvalid = 0; gpio_we = 0; gpio_a = 0; gpio_wd = 0; m0_rd = m1_rd = 0; busy = 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, select the winner: the only requester, or the pointer's master if both request.
  - Latch the winner's a/we/wd and id, then go to ACCESS.
  - If no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - gpio_a = latched a; gpio_wd = latched wd; gpio_we = latched we & ~RST.
  - Winner's gnt = 1.
  - On a read, capture gpio_rd into the winner's rd register at the end of the cycle.
  - Next state: RESP.
- RESP (exactly 1 cycle):
  - Winner's rvalid = 1 for both reads and writes.
  - Pointer moves to the other master.
  - Next state: IDLE.
- Timing:
  - Latency from req sampled in IDLE: gnt +1 cycle, rvalid +2 cycles.
  - Throughput: one access per 3 cycles.
- Request lifetime:
  - The requester may drop req in the cycle after gnt.
  - A req still high in IDLE after rvalid is treated as a new access.
- gpio_we is high only in ACCESS, never for reads, and never for two consecutive cycles.
- The loser's request is not lost; it wins the next IDLE.
- Outside ACCESS, gpio_a/gpio_wd hold their last values and gpio_we = 0.
- RST during ACCESS or RESP: the access is aborted.
  - gpio_we is forced 0 in that cycle.
  - No rvalid is issued.
  - The FSM is in IDLE in the next cycle.
- The non-winning master's rd register is never modified.

Optional Feature:
- Macro: GPIO_ARB_LOCK_EN.
- With the macro defined:
  - Adds input ports m0_lock and m1_lock (1 bit each).
  - In RESP, if the winner's lock and req are both high and its hold count < MAX_HOLD, latch its new command and go directly to ACCESS. The pointer is not moved and hold count increments.
  - Throughput under lock: one access per 2 cycles.
  - Hold count clears in IDLE and on reset.
  - When the count reaches MAX_HOLD, the master is forced to release; normal round-robin applies.
- Without the macro: no lock ports, MAX_HOLD is unused, and RESP always returns to IDLE.

Decomposition:
- Package gpio_arb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - the master-id type (M0 = 0, M1 = 1);
  - AW/DW default constants.
- Sub-module gpio_arb_rr: combinational round-robin winner select plus the pointer register.
- The FSM and datapath latches stay in gpio_arbiter.

Test Plan:
1. Reset: assert RST for 1 tick with m0_req = 1 -> all outputs 0, no gnt. The first gnt after release goes to m0 on the second cycle.
2. m0 write, A=2, WD=3 -> m0_gnt at +1; gpio_we = 1, gpio_a = 2, gpio_wd = 3 for exactly one cycle; m0_rvalid at +2; m1 outputs idle.
3. Simultaneous reads: m0 A=0, m1 A=1, with the gpio model returning 5 for A=0 and 7 for A=1 -> m0_rd = 5 with m0_rvalid first; m1_rd = 7 with m1_rvalid 3 cycles later; gpio_we stays 0 throughout.
4. Fairness: both masters hold req for 6 accesses -> grants alternate 0,1,0,1,0,1, and busy never drops below 1 idle cycle per access.
5. RST asserted in the ACCESS cycle of an m1 write A=3, WD=9 -> gpio_we = 0 in that cycle, no m1_rvalid, IDLE next cycle, pointer = m0.
6. (GPIO_ARB_LOCK_EN) m1_lock = 1 with both requesting continuously -> m1 receives 4 consecutive gnts spaced 2 cycles apart, then m0 is granted.
